// File: rtl/led_ctrl_pkg.sv
// Shared codes, reset constants and pattern helpers for the LED pattern engine.
package led_ctrl_pkg;

    typedef enum logic [3:0] {
        MODE_OFF   = 4'd0,
        MODE_ON    = 4'd1,
        MODE_RUN_L = 4'd2,
        MODE_RUN_R = 4'd3,
        MODE_BLINK = 4'd4,
        MODE_COUNT = 4'd5
    } led_mode_e;

    typedef enum logic [3:0] {
        UNIT_US = 4'd0,
        UNIT_MS = 4'd1,
        UNIT_S  = 4'd2
    } time_unit_e;

    localparam logic [7:0] CFG_NUM_RST  = 8'd3;
    localparam logic [3:0] CFG_UNIT_RST = 4'd1;

    function automatic logic unit_valid(input logic [3:0] unit);
        return (unit == UNIT_US) || (unit == UNIT_MS) || (unit == UNIT_S);
    endfunction

    function automatic logic [3:0] led_init(input logic [3:0] mode);
        logic [3:0] value;
        value = 4'b0000;
        case (mode)
            MODE_ON:    value = 4'b1111;
            MODE_RUN_L: value = 4'b0001;
            MODE_RUN_R: value = 4'b1000;
            MODE_BLINK: value = 4'b1111;
            default:    value = 4'b0000;
        endcase
        return value;
    endfunction

    function automatic logic [3:0] led_next(input logic [3:0] mode, input logic [3:0] cur);
        logic [3:0] value;
        value = 4'b0000;
        case (mode)
            MODE_ON:    value = 4'b1111;
            MODE_RUN_L: value = {cur[2:0], cur[3]};
            MODE_RUN_R: value = {cur[0], cur[3:1]};
            MODE_BLINK: value = ~cur;
            MODE_COUNT: value = cur + 4'd1;
            default:    value = 4'b0000;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Base time tick chain: cycle counter -> us, two UNIT_SCALE prescalers -> ms, s.
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int TICKS_PER_US = 50,
    parameter int UNIT_SCALE   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] unit,
    output logic       unit_tick
);

    localparam int CYC_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int SCL_W = (UNIT_SCALE > 1) ? $clog2(UNIT_SCALE) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICKS_PER_US - 1);
    localparam logic [SCL_W-1:0] SCL_LAST = SCL_W'(UNIT_SCALE - 1);

    logic [CYC_W-1:0] cyc_cnt_reg;
    // ticks[0] = us, ticks[1] = ms, ticks[2] = s
    logic [2:0]       ticks;

    assign ticks[0] = (cyc_cnt_reg == CYC_LAST);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cyc_cnt_reg <= '0;
        end else if (ticks[0]) begin
            cyc_cnt_reg <= '0;
        end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_prescale
        logic [SCL_W-1:0] cnt_reg;

        assign ticks[gi+1] = ticks[gi] && (cnt_reg == SCL_LAST);

        always_ff @(posedge clk) begin
            if (!reset || clear) begin
                cnt_reg <= '0;
            end else if (ticks[gi]) begin
                cnt_reg <= ticks[gi+1] ? '0 : cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        unit_tick = ticks[0];
        case (unit)
            UNIT_MS: unit_tick = ticks[1];
            UNIT_S:  unit_tick = ticks[2];
            default: unit_tick = ticks[0];
        endcase
    end

endmodule

// File: rtl/led_ctrl.sv
// Timed LED pattern engine: config registers, interval counter, pattern
// register and read-response port on top of the led_tick_gen time base.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICKS_PER_US = 50,
    parameter int UNIT_SCALE   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        time_control_en,
    input  logic [7:0]  time_num,
    input  logic [3:0]  time_unit,
    input  logic        led_mode_en,
    input  logic [3:0]  led_mode,
    input  logic        rd_led_mode_en,
    input  logic        rd_led_time_en,
    output logic [3:0]  led,
    output logic        rd_valid,
    output logic [15:0] rd_data
);

    logic [7:0]  cfg_num_reg;
    logic [3:0]  cfg_unit_reg;
    logic [3:0]  cfg_mode_reg;
    logic [7:0]  int_cnt_reg;
    logic [3:0]  led_reg;
    logic        rd_valid_reg;
    logic [15:0] rd_data_reg;

    logic        time_ok;
    logic        restart;
    logic [3:0]  mode_next;
    logic [7:0]  int_last;
    logic        unit_tick;
    logic        step;

    assign time_ok   = time_control_en && unit_valid(time_unit);
    assign restart   = time_ok || led_mode_en;
    assign mode_next = led_mode_en ? led_mode : cfg_mode_reg;
    // An interval count of 0 is treated as 1.
    assign int_last  = (cfg_num_reg == 8'd0) ? 8'd0 : cfg_num_reg - 8'd1;
    assign step      = unit_tick && (int_cnt_reg == int_last);

    led_tick_gen #(
        .TICKS_PER_US (TICKS_PER_US),
        .UNIT_SCALE   (UNIT_SCALE)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .unit      (cfg_unit_reg),
        .unit_tick (unit_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_num_reg  <= CFG_NUM_RST;
            cfg_unit_reg <= CFG_UNIT_RST;
            cfg_mode_reg <= MODE_OFF;
            int_cnt_reg  <= 8'd0;
            led_reg      <= 4'b0000;
        end else begin
            if (time_ok) begin
                cfg_num_reg  <= time_num;
                cfg_unit_reg <= time_unit;
            end
            if (led_mode_en) begin
                cfg_mode_reg <= led_mode;
            end
            // A config write overrides any step landing in the same cycle.
            if (restart) begin
                int_cnt_reg <= 8'd0;
                led_reg     <= led_init(mode_next);
            end else if (step) begin
                int_cnt_reg <= 8'd0;
                led_reg     <= led_next(cfg_mode_reg, led_reg);
            end else if (unit_tick) begin
                int_cnt_reg <= int_cnt_reg + 8'd1;
            end
        end
    end

    // Reads sample the registers before any write in the same cycle lands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= 16'h0000;
        end else begin
            rd_valid_reg <= rd_led_mode_en || rd_led_time_en;
            if (rd_led_mode_en) begin
                rd_data_reg <= {12'h000, cfg_mode_reg};
            end else if (rd_led_time_en) begin
                rd_data_reg <= {cfg_num_reg, cfg_unit_reg, 4'h0};
            end
        end
    end

    assign led      = led_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed and randomized checks of led_ctrl against a cycles-since-restart model.
module tb_led_ctrl;

    localparam int TPU = 2;
    localparam int US  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        time_control_en = 1'b0;
    logic [7:0]  time_num = 8'd0;
    logic [3:0]  time_unit = 4'd0;
    logic        led_mode_en = 1'b0;
    logic [3:0]  led_mode = 4'd0;
    logic        rd_led_mode_en = 1'b0;
    logic        rd_led_time_en = 1'b0;
    logic [3:0]  led;
    logic        rd_valid;
    logic [15:0] rd_data;

    int checks = 0;
    int failures = 0;

    led_ctrl #(.TICKS_PER_US(TPU), .UNIT_SCALE(US)) dut (
        .clk             (clk),
        .reset           (reset),
        .time_control_en (time_control_en),
        .time_num        (time_num),
        .time_unit       (time_unit),
        .led_mode_en     (led_mode_en),
        .led_mode        (led_mode),
        .rd_led_mode_en  (rd_led_mode_en),
        .rd_led_time_en  (rd_led_time_en),
        .led             (led),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: config plus the number of cycles since the last restart.
    logic [7:0]  m_num = 8'd3;
    logic [3:0]  m_unit = 4'd1;
    logic [3:0]  m_mode = 4'd0;
    int          m_elapsed = 0;
    logic        m_rd_valid = 1'b0;
    logic [15:0] m_rd_data = 16'h0000;

    function automatic int period(input logic [7:0] num, input logic [3:0] unit);
        int scale;
        int n;
        scale = (unit == 4'd0) ? 1 : (unit == 4'd1) ? US : US * US;
        n = (num == 8'd0) ? 1 : int'(num);
        return TPU * scale * n;
    endfunction

    function automatic logic [3:0] pattern(input logic [3:0] mode, input int k);
        logic [3:0] one;
        logic [3:0] eight;
        one = 4'b0001;
        eight = 4'b1000;
        case (mode)
            4'd1:    return 4'b1111;
            4'd2:    return one << (k % 4);
            4'd3:    return eight >> (k % 4);
            4'd4:    return ((k % 2) == 0) ? 4'b1111 : 4'b0000;
            4'd5:    return 4'(k % 16);
            default: return 4'b0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_num      <= 8'd3;
            m_unit     <= 4'd1;
            m_mode     <= 4'd0;
            m_elapsed  <= 0;
            m_rd_valid <= 1'b0;
            m_rd_data  <= 16'h0000;
        end else begin
            m_rd_valid <= rd_led_mode_en | rd_led_time_en;
            if (rd_led_mode_en)
                m_rd_data <= {12'h000, m_mode};
            else if (rd_led_time_en)
                m_rd_data <= {m_num, m_unit, 4'h0};
            if (time_control_en && time_unit <= 4'd2) begin
                m_num  <= time_num;
                m_unit <= time_unit;
            end
            if (led_mode_en)
                m_mode <= led_mode;
            if ((time_control_en && time_unit <= 4'd2) || led_mode_en)
                m_elapsed <= 0;
            else
                m_elapsed <= m_elapsed + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, drop one-shot pulses, compare to model.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            time_control_en = 1'b0;
            led_mode_en     = 1'b0;
            rd_led_mode_en  = 1'b0;
            rd_led_time_en  = 1'b0;
            chk("model_led", {12'h000, led},
                {12'h000, pattern(m_mode, m_elapsed / period(m_num, m_unit))});
            chk("model_rd_valid", {15'h0000, rd_valid}, {15'h0000, m_rd_valid});
            chk("model_rd_data", rd_data, m_rd_data);
        end
    endtask

    task automatic wr_time(input logic [7:0] num, input logic [3:0] unit);
        time_control_en = 1'b1;
        time_num = num;
        time_unit = unit;
    endtask

    task automatic wr_mode(input logic [3:0] mode);
        led_mode_en = 1'b1;
        led_mode = mode;
    endtask

    logic [3:0] run_seq [4];
    int r;

    initial begin
        run_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset defaults
        reset = 1'b0;
        cyc(3);
        reset = 1'b1;
        chk("rst_led", {12'h000, led}, 16'h0000);
        chk("rst_rd_valid", {15'h0000, rd_valid}, 16'h0000);
        chk("rst_rd_data", rd_data, 16'h0000);
        rd_led_time_en = 1'b1;
        cyc(1);
        chk("rst_time_word", rd_data, 16'h0310);
        chk("rst_time_valid", {15'h0000, rd_valid}, 16'h0001);

        // Running light left, 3 us interval = 6 cycles
        wr_time(8'd3, 4'd0);
        cyc(1);
        wr_mode(4'd2);
        cyc(1);
        chk("runl_init", {12'h000, led}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            cyc(5);
            chk("runl_hold", {12'h000, led}, {12'h000, (i == 0) ? 4'b0001 : run_seq[i-1]});
            cyc(1);
            chk("runl_step", {12'h000, led}, {12'h000, run_seq[i]});
        end

        // Blink, num 0 treated as 1, ms unit = 8 cycles; both writes together
        wr_time(8'd0, 4'd1);
        wr_mode(4'd4);
        cyc(1);
        chk("blink_init", {12'h000, led}, 16'h000f);
        cyc(7);
        chk("blink_hold", {12'h000, led}, 16'h000f);
        cyc(1);
        chk("blink_off", {12'h000, led}, 16'h0000);
        cyc(7);
        chk("blink_off_hold", {12'h000, led}, 16'h0000);
        cyc(1);
        chk("blink_on", {12'h000, led}, 16'h000f);

        // Invalid unit code is ignored entirely
        cyc(3);
        wr_time(8'd9, 4'd7);
        cyc(1);
        chk("inval_no_restart", {12'h000, led}, 16'h000f);
        cyc(3);
        chk("inval_hold", {12'h000, led}, 16'h000f);
        cyc(1);
        chk("inval_step", {12'h000, led}, 16'h0000);
        rd_led_time_en = 1'b1;
        cyc(1);
        chk("inval_time_word", rd_data, 16'h0010);

        // Reads: simultaneous strobes (mode wins), then time alone, then hold
        wr_mode(4'd5);
        cyc(1);
        chk("count_init", {12'h000, led}, 16'h0000);
        rd_led_mode_en = 1'b1;
        rd_led_time_en = 1'b1;
        cyc(1);
        chk("rd_both_data", rd_data, 16'h0005);
        chk("rd_both_valid", {15'h0000, rd_valid}, 16'h0001);
        rd_led_time_en = 1'b1;
        cyc(1);
        chk("rd_time_data", rd_data, 16'h0010);
        chk("rd_time_valid", {15'h0000, rd_valid}, 16'h0001);
        cyc(1);
        chk("rd_idle_valid", {15'h0000, rd_valid}, 16'h0000);
        chk("rd_hold_data", rd_data, 16'h0010);

        // Mode write in the exact step cycle wins over the step
        cyc(4);
        chk("count_pre", {12'h000, led}, 16'h0000);
        cyc(1);
        chk("count_step1", {12'h000, led}, 16'h0001);
        cyc(7);
        wr_mode(4'd5);
        cyc(1);
        chk("collide_led", {12'h000, led}, 16'h0000);
        cyc(7);
        chk("collide_hold", {12'h000, led}, 16'h0000);
        cyc(1);
        chk("collide_step", {12'h000, led}, 16'h0001);

        // Reset mid-interval
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("midrst_led", {12'h000, led}, 16'h0000);
        cyc(1);
        reset = 1'b1;
        rd_led_mode_en = 1'b1;
        cyc(1);
        chk("midrst_mode_word", rd_data, 16'h0000);

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 299));
            reset = (r != 0);
            if ($urandom_range(0, 29) == 0)
                wr_time(8'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 24) == 0)
                wr_mode(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(2, 5)));
            rd_led_mode_en = ($urandom_range(0, 7) == 0);
            rd_led_time_en = ($urandom_range(0, 7) == 0);
            cyc(1);
        end
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
